// File: rtl/bcd_calc_engine.sv
// rtl/bcd_calc_engine.sv - signed BCD entry registers with a digit-serial add/subtract engine
// Optional memory register is built when CALC_MEMORY_EN is defined.
module bcd_calc_engine #(
   parameter int DIGITS = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  dig_strobe,
   input  logic [3:0]            dig_code,
   input  logic                  op_strobe,
   input  logic [1:0]            op_code,
   input  logic                  ex_strobe,
   input  logic                  bksp_strobe,
   input  logic                  clear_strobe,
   input  logic                  ms_strobe,
   input  logic                  mr_strobe,
   input  logic                  mc_strobe,
   output logic [4*DIGITS-1:0]   disp_bcd,
   output logic                  disp_neg,
   output logic [1:0]            disp_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  mem_valid
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] FULL = CW'(DIGITS);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [2:0] {S_A, S_B, S_ADD, S_FIX, S_RES} state_t;

   state_t          state_q;
   logic [W-1:0]    a_q, b_q, res_q, x_q, y_q;
   logic [CW-1:0]   a_cnt_q, b_cnt_q, idx_q;
   logic            a_neg_q, res_neg_q, op_q, carry_q, diff_q;
   logic            busy_q, done_q, ovf_q;

   logic [4:0]      add_sum, fix_sum;
   logic            add_cy, fix_cy, src_neg, diff_d;
   logic [3:0]      add_dig, fix_dig;
   logic [W-1:0]    add_res_d, fix_res_d, src_mag;

   function automatic logic [CW-1:0] sig_digits(input logic [W-1:0] v);
      sig_digits = '0;
      for (int i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] != 4'd0) sig_digits = CW'(i + 1);
   endfunction

   function automatic logic [W-1:0] nines(input logic [W-1:0] v);
      nines = '0;
      for (int i = 0; i < DIGITS; i++)
         nines[4*i +: 4] = 4'd9 - v[4*i +: 4];
   endfunction

   // One BCD digit per clock: operands drain from the bottom, results enter at the top.
   always_comb begin
      add_sum   = {1'b0, x_q[3:0]} + {1'b0, y_q[3:0]} + {4'd0, carry_q};
      add_cy    = add_sum > 5'd9;
      add_dig   = add_cy ? 4'(add_sum - 5'd10) : add_sum[3:0];
      add_res_d = {add_dig, res_q[W-1:4]};
      fix_sum   = {1'b0, 4'd9 - res_q[3:0]} + {4'd0, carry_q};
      fix_cy    = fix_sum > 5'd9;
      fix_dig   = fix_cy ? 4'(fix_sum - 5'd10) : fix_sum[3:0];
      fix_res_d = {fix_dig, res_q[W-1:4]};
      src_mag   = (state_q == S_RES) ? res_q : a_q;
      src_neg   = (state_q == S_RES) ? res_neg_q : a_neg_q;
      diff_d    = src_neg ^ op_q;
   end

   always_comb begin
      disp_bcd = b_q;
      disp_neg = 1'b0;
      disp_sel = 2'b01;
      case (state_q)
         S_A:     begin disp_bcd = a_q;   disp_neg = a_neg_q;   disp_sel = 2'b00; end
         S_RES:   begin disp_bcd = res_q; disp_neg = res_neg_q; disp_sel = 2'b10; end
         default: ;
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;

`ifdef CALC_MEMORY_EN
   logic [W-1:0] mem_q;
   logic         mem_neg_q, mem_valid_q;
   assign mem_valid = mem_valid_q;
`else
   logic unused_mem_strobes;
   assign unused_mem_strobes = ms_strobe ^ mr_strobe ^ mc_strobe;
   assign mem_valid = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_A;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         a_cnt_q   <= '0;
         b_cnt_q   <= '0;
         idx_q     <= '0;
         a_neg_q   <= 1'b0;
         res_neg_q <= 1'b0;
         op_q      <= 1'b0;
         carry_q   <= 1'b0;
         diff_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
`ifdef CALC_MEMORY_EN
         mem_q       <= '0;
         mem_neg_q   <= 1'b0;
         mem_valid_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (clear_strobe) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
            idx_q     <= '0;
            a_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
            op_q      <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
         end else begin
            case (state_q)
               S_ADD: begin
                  x_q     <= {4'd0, x_q[W-1:4]};
                  y_q     <= {4'd0, y_q[W-1:4]};
                  res_q   <= add_res_d;
                  carry_q <= add_cy;
                  idx_q   <= idx_q + CW'(1);
                  if (idx_q == LAST) begin
                     idx_q <= '0;
                     if (diff_q && !add_cy) begin
                        state_q <= S_FIX;
                        carry_q <= 1'b1;
                     end else begin
                        state_q   <= S_RES;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        ovf_q     <= !diff_q && add_cy;
                        res_neg_q <= (add_res_d == '0) ? 1'b0 : a_neg_q;
                     end
                  end
               end
               // Signs differed and A < B: ten's-complement the raw sum, sign flips.
               S_FIX: begin
                  res_q   <= fix_res_d;
                  carry_q <= fix_cy;
                  idx_q   <= idx_q + CW'(1);
                  if (idx_q == LAST) begin
                     idx_q     <= '0;
                     state_q   <= S_RES;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     res_neg_q <= (fix_res_d == '0) ? 1'b0 : !a_neg_q;
                  end
               end
               default: begin
                  if (ex_strobe) begin
                     if (state_q == S_B || (state_q == S_RES && !ovf_q)) begin
                        if (state_q == S_RES) begin
                           a_q     <= res_q;
                           a_neg_q <= res_neg_q;
                           a_cnt_q <= sig_digits(res_q);
                        end
                        x_q     <= src_mag;
                        y_q     <= diff_d ? nines(b_q) : b_q;
                        carry_q <= diff_d;
                        diff_q  <= diff_d;
                        idx_q   <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADD;
                     end
                  end else if (op_strobe) begin
                     if (!op_code[1] && (state_q != S_RES || !ovf_q)) begin
                        op_q <= op_code[0];
                        if (state_q == S_RES) begin
                           a_q     <= res_q;
                           a_neg_q <= res_neg_q;
                           a_cnt_q <= sig_digits(res_q);
                        end
                        if (state_q != S_B) begin
                           b_q     <= '0;
                           b_cnt_q <= '0;
                           state_q <= S_B;
                        end
                     end
                  end else if (bksp_strobe) begin
                     if (state_q == S_A && a_cnt_q != '0) begin
                        a_q     <= {4'd0, a_q[W-1:4]};
                        a_cnt_q <= a_cnt_q - CW'(1);
                     end else if (state_q == S_B && b_cnt_q != '0) begin
                        b_q     <= {4'd0, b_q[W-1:4]};
                        b_cnt_q <= b_cnt_q - CW'(1);
                     end
                  end else if (dig_strobe) begin
                     if (dig_code <= 4'd9) begin
                        if (state_q == S_A) begin
                           a_neg_q <= 1'b0;
                           if (a_cnt_q != FULL && (a_cnt_q != '0 || dig_code != 4'd0)) begin
                              a_q     <= {a_q[W-5:0], dig_code};
                              a_cnt_q <= a_cnt_q + CW'(1);
                           end
                        end else if (state_q == S_B) begin
                           if (b_cnt_q != FULL && (b_cnt_q != '0 || dig_code != 4'd0)) begin
                              b_q     <= {b_q[W-5:0], dig_code};
                              b_cnt_q <= b_cnt_q + CW'(1);
                           end
                        end else begin
                           a_q     <= {{(W-4){1'b0}}, dig_code};
                           a_cnt_q <= (dig_code != 4'd0) ? CW'(1) : '0;
                           a_neg_q <= 1'b0;
                           b_q     <= '0;
                           b_cnt_q <= '0;
                           state_q <= S_A;
                        end
                     end
                  end
`ifdef CALC_MEMORY_EN
                  else if (ms_strobe) begin
                     mem_q       <= disp_bcd;
                     mem_neg_q   <= disp_neg;
                     mem_valid_q <= 1'b1;
                  end else if (mr_strobe) begin
                     if (mem_valid_q) begin
                        if (state_q == S_B) begin
                           b_q     <= mem_q;
                           b_cnt_q <= sig_digits(mem_q);
                           if (mem_neg_q) op_q <= !op_q;
                        end else begin
                           a_q     <= mem_q;
                           a_neg_q <= mem_neg_q;
                           a_cnt_q <= sig_digits(mem_q);
                           state_q <= S_A;
                        end
                     end
                  end else if (mc_strobe) begin
                     mem_q       <= '0;
                     mem_neg_q   <= 1'b0;
                     mem_valid_q <= 1'b0;
                  end
`endif
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bcd_calc_engine.sv
// tb/tb_bcd_calc_engine.sv - directed vector bench for bcd_calc_engine (DIGITS = 4)
module tb_bcd_calc_engine;
   localparam int K_DIG = 0, K_OP = 1, K_EX = 2, K_BKSP = 3, K_CLR = 4, K_MS = 5, K_MR = 6;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        dig_strobe = 0, op_strobe = 0, ex_strobe = 0, bksp_strobe = 0, clear_strobe = 0;
   logic        ms_strobe = 0, mr_strobe = 0, mc_strobe = 0;
   logic [3:0]  dig_code = 0;
   logic [1:0]  op_code = 0;
   logic [15:0] disp_bcd;
   logic        disp_neg, busy, done, overflow, mem_valid;
   logic [1:0]  disp_sel;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] a;
      logic        op;
      logic [15:0] b;
      logic [15:0] res;
      logic        neg;
      logic        ovf;
      logic [3:0]  lat;
   } vec_t;

   vec_t vecs[9];

   bcd_calc_engine #(.DIGITS(4)) dut (
      .clock(clk), .reset_n(rst_n),
      .dig_strobe(dig_strobe), .dig_code(dig_code),
      .op_strobe(op_strobe), .op_code(op_code),
      .ex_strobe(ex_strobe), .bksp_strobe(bksp_strobe), .clear_strobe(clear_strobe),
      .ms_strobe(ms_strobe), .mr_strobe(mr_strobe), .mc_strobe(mc_strobe),
      .disp_bcd(disp_bcd), .disp_neg(disp_neg), .disp_sel(disp_sel),
      .busy(busy), .done(done), .overflow(overflow), .mem_valid(mem_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic press(input int k, input logic [3:0] v);
      @(negedge clk);
      case (k)
         K_DIG:  begin dig_strobe = 1; dig_code = v; end
         K_OP:   begin op_strobe = 1; op_code = v[1:0]; end
         K_EX:   ex_strobe = 1;
         K_BKSP: bksp_strobe = 1;
         K_CLR:  clear_strobe = 1;
         K_MS:   ms_strobe = 1;
         K_MR:   mr_strobe = 1;
         default: ;
      endcase
      @(negedge clk);
      {dig_strobe, op_strobe, ex_strobe, bksp_strobe, clear_strobe} = '0;
      {ms_strobe, mr_strobe, mc_strobe} = '0;
   endtask

   task automatic enter_num(input logic [15:0] v);
      logic started = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (v[4*i +: 4] != 4'd0) started = 1'b1;
         if (started) press(K_DIG, v[4*i +: 4]);
      end
   endtask

   task automatic run_ex(input logic also_op, output int lat, output int busy_n);
      @(negedge clk);
      ex_strobe = 1;
      if (also_op) begin op_strobe = 1; op_code = 2'b01; end
      lat = 0;
      busy_n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         ex_strobe = 0;
         op_strobe = 0;
         if (busy) busy_n++;
         if (done) begin lat = k; break; end
      end
   endtask

   task automatic calc(input logic [15:0] a, input logic op, input logic [15:0] b,
                       output int lat, output int busy_n);
      press(K_CLR, 0);
      enter_num(a);
      press(K_OP, {3'b0, op});
      enter_num(b);
      run_ex(1'b0, lat, busy_n);
   endtask

   initial begin
      int lat, busy_n, seen;
      vecs[0] = '{16'h0123, 1'b0, 16'h0045, 16'h0168, 1'b0, 1'b0, 4'd5};
      vecs[1] = '{16'h0045, 1'b1, 16'h0123, 16'h0078, 1'b1, 1'b0, 4'd9};
      vecs[2] = '{16'h9999, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1, 4'd5};
      vecs[3] = '{16'h0500, 1'b1, 16'h0500, 16'h0000, 1'b0, 1'b0, 4'd5};
      vecs[4] = '{16'h1000, 1'b1, 16'h0001, 16'h0999, 1'b0, 1'b0, 4'd5};
      vecs[5] = '{16'h0000, 1'b1, 16'h0007, 16'h0007, 1'b1, 1'b0, 4'd9};
      vecs[6] = '{16'h5000, 1'b0, 16'h5000, 16'h0000, 1'b0, 1'b1, 4'd5};
      vecs[7] = '{16'h4321, 1'b0, 16'h5678, 16'h9999, 1'b0, 1'b0, 4'd5};
      vecs[8] = '{16'h0001, 1'b1, 16'h9999, 16'h9998, 1'b1, 1'b0, 4'd9};

      #1;
      check("reset_outputs", {disp_bcd, disp_neg, disp_sel, busy, done, overflow, mem_valid}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_outputs", {disp_bcd, disp_neg, disp_sel, busy, done, overflow}, 0);

      for (int i = 0; i < 9; i++) begin
         calc(vecs[i].a, vecs[i].op, vecs[i].b, lat, busy_n);
         check($sformatf("v%0d_latency", i), lat, {28'd0, vecs[i].lat});
         check($sformatf("v%0d_busy_cycles", i), busy_n, {28'd0, vecs[i].lat} - 1);
         check($sformatf("v%0d_bcd", i), disp_bcd, vecs[i].res);
         check($sformatf("v%0d_neg", i), disp_neg, vecs[i].neg);
         check($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
         check($sformatf("v%0d_sel", i), disp_sel, 2'b10);
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), done, 0);
      end

      calc(16'h9999, 1'b0, 16'h0001, lat, busy_n);
      press(K_OP, 4'd0);
      check("ovf_op_ignored", {disp_sel, disp_bcd, overflow}, {2'b10, 16'h0000, 1'b1});
      press(K_EX, 0);
      check("ovf_ex_ignored", {busy, disp_sel}, {1'b0, 2'b10});

      press(K_CLR, 0);
      for (int d = 1; d <= 5; d++) press(K_DIG, 4'(d));
      check("entry_full", disp_bcd, 16'h1234);
      repeat (2) press(K_BKSP, 0);
      check("bksp_two", disp_bcd, 16'h0012);
      repeat (3) press(K_BKSP, 0);
      check("bksp_underflow", {disp_sel, disp_bcd, disp_neg}, 0);
      for (int d = 0; d <= 8; d++) press(K_DIG, (d < 5) ? 4'd0 : 4'(d - 4));
      check("leading_zeros", disp_bcd, 16'h1234);
      press(K_DIG, 4'd12);
      check("digit_code_gt9", disp_bcd, 16'h1234);

      calc(16'h0045, 1'b1, 16'h0123, lat, busy_n);
      check("chain_first", {disp_neg, disp_bcd}, {1'b1, 16'h0078});
      press(K_OP, 4'd0);
      check("chain_to_b", {disp_sel, disp_bcd}, {2'b01, 16'h0000});
      enter_num(16'h0100);
      run_ex(1'b0, lat, busy_n);
      check("chain_second", {disp_neg, disp_bcd}, {1'b0, 16'h0022});
      check("chain_second_lat", lat, 9);
      run_ex(1'b0, lat, busy_n);
      check("repeat_equals", {disp_neg, disp_bcd}, {1'b0, 16'h0122});
      check("repeat_equals_lat", lat, 5);

      press(K_CLR, 0);
      enter_num(16'h0005);
      press(K_OP, 4'd0);
      enter_num(16'h0003);
      run_ex(1'b1, lat, busy_n);
      check("prio_ex_over_op", {disp_neg, disp_bcd}, {1'b0, 16'h0008});

      press(K_CLR, 0);
      enter_num(16'h0012);
      @(negedge clk);
      bksp_strobe = 1; dig_strobe = 1; dig_code = 4'd7;
      @(negedge clk);
      bksp_strobe = 0; dig_strobe = 0;
      check("prio_bksp_over_dig", disp_bcd, 16'h0001);
      press(K_OP, 4'd2);
      check("reserved_op", disp_sel, 2'b00);

      calc(16'h0001, 1'b0, 16'h0001, lat, busy_n);
      press(K_DIG, 4'd4);
      check("res_digit_new_a", {disp_sel, disp_neg, disp_bcd}, {2'b00, 1'b0, 16'h0004});

      press(K_CLR, 0);
      enter_num(16'h0045);
      press(K_OP, 4'd1);
      enter_num(16'h0123);
      @(negedge clk);
      ex_strobe = 1;
      @(negedge clk);
      ex_strobe = 0;
      clear_strobe = 1;
      @(negedge clk);
      clear_strobe = 0;
      check("clear_mid_op", {busy, disp_sel}, {1'b0, 2'b00});
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("clear_no_done", seen, 0);

`ifdef CALC_MEMORY_EN
      press(K_DIG, 4'd6);
      press(K_MS, 0);
      check("mem_store", mem_valid, 1);
`else
      press(K_DIG, 4'd6);
      press(K_MS, 0);
      press(K_MR, 0);
      check("mem_disabled", {mem_valid, disp_bcd}, {1'b0, 16'h0006});
`endif

      press(K_CLR, 0);
      enter_num(16'h0045);
      press(K_OP, 4'd1);
      enter_num(16'h0123);
      @(negedge clk);
      ex_strobe = 1;
      repeat (7) begin
         @(negedge clk);
         ex_strobe = 0;
      end
      check("midfix_busy", {busy, disp_sel}, {1'b1, 2'b01});
      rst_n = 1'b0;
      #1;
      check("async_reset", {disp_bcd, disp_neg, disp_sel, busy, done, overflow, mem_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
